addsub_seq_chunked: RTL and testbench
=====================================

Name: addsub_seq_chunked

Overview:
- Multi-cycle N-bit adder/subtractor. Processes the operands CHUNK bits per clock, LSB chunk first, with a ripple carry held in a register between cycles.
- Generalises the 4-bit ripple adder in three ways: width, per-cycle slice size, and an add/subtract mode.
- Adds a start/busy/done handshake plus carry, overflow and zero flags.
- Serves as the arithmetic unit for wider datapaths where a full-width single-cycle ripple is too slow.

Parameters:
- WIDTH, 16: operand/result width. Must be a multiple of CHUNK.
- CHUNK, 4: bits processed per clock cycle. NCHUNK = WIDTH/CHUNK, which must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only while in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract. Sampled with start.
- A  input  WIDTH  operand A. Sampled with start.
- B  input  WIDTH  operand B. Sampled with start.
- Cin  input  1  carry-in (add) or borrow-in (sub). Sampled with start.
- busy  output  1  high while chunks are being processed.
- done  output  1  one-cycle pulse: results updated.
- Sum  output  WIDTH  result, registered.
- Cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- Ovf  output  1  two's-complement signed overflow.
- Zero  output  1  Sum == 0.

Behaviour:
- Reset: one clock with rst high forces the following, regardless of state, including mid-RUN:
  - state = IDLE, chunk index = 0;
  - busy = 0, done = 0;
  - Sum = 0, Cout = 0, Ovf = 0, Zero = 0;
  - internal operand and carry registers = 0.
  - A run in progress is discarded with no done pulse.
- Arithmetic:
  - add: Sum = A + B + Cin.
  - sub: Sum = A + ~B + ~Cin, i.e. A - B - Cin.
  - B inversion and carry-in inversion are applied when the operands are latched.
  - Results are modulo 2^WIDTH.
- States: IDLE, RUN, DONE.
  - IDLE, start=1: latch A, B', carry = Cin'. Chunk index = 0. Go to RUN. start=0: stay.
  - RUN, each cycle: add chunk[idx] of A and B' plus the carry register with a CHUNK-bit ripple. Store the result slice and update the carry register.
    - idx < NCHUNK-1: idx+1, stay in RUN.
    - idx == NCHUNK-1: load Sum, Cout, Ovf and Zero from the complete result. Go to DONE.
  - DONE: done = 1 for exactly this cycle.
    - start=1: accepted exactly as in IDLE (back-to-back operation, go to RUN).
    - start=0: go to IDLE.
- Handshake and latency:
  - start sampled at edge t → busy = 1 for cycles t+1 .. t+NCHUNK → done = 1 in cycle t+NCHUNK+1.
  - Throughput is one operation per NCHUNK+1 cycles.
- start while busy is ignored; no queueing. Changes on A, B, sub or Cin after the sampling edge have no effect on the running operation.
- Sum and the flags hold their last values until the next completion. They never show partial results. busy and done are registered outputs.
- Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, taken from the last chunk.
- Zero is computed on the full WIDTH-bit result.
- CHUNK == WIDTH: single RUN cycle (NCHUNK = 1), same handshake and 2-cycle start-to-done latency.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- Add 0x1234 + 0x0FFF, Cin=0 → done in cycle t+5; Sum=0x2233, Cout=0, Ovf=0, Zero=0. busy high for exactly 4 cycles.
- Add 0x7FFF + 0x0001 → Sum=0x8000, Ovf=1, Cout=0. Add 0xFFFF + 0x0000, Cin=1 → Sum=0x0000, Cout=1, Zero=1, Ovf=0.
- Sub 0x0005 - 0x0007, Cin=0 → Sum=0xFFFE, Cout=0 (borrow), Ovf=0. Sub 0x8000 - 0x0001 → Sum=0x7FFF, Cout=1, Ovf=1.
- Pulse start again while busy, with different operands → ignored; the first result completes unchanged. start held high during DONE → the second operation is accepted and its done pulse arrives 5 cycles later.
- Assert rst for 1 cycle in the 2nd RUN cycle → all outputs 0 and state IDLE on the next cycle; no done pulse; a following operation completes correctly.
- Random regression with WIDTH=12/CHUNK=3 and WIDTH=8/CHUNK=8 → Sum, Cout and Ovf match a reference model for 1000 random A/B/Cin/sub vectors.

Source files
------------

// File: rtl/addsub_seq_chunked.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples CHUNK bits per clock,
// LSB chunk first, with a start/busy/done handshake and carry/overflow/zero flags.
module addsub_seq_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;     // B already inverted for subtract
    logic             carry;
    logic [WIDTH-1:0] res;     // partial result, never visible on Sum

    logic [31:0]      base;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] res_next;

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path leaves it unassigned, which is what keeps this block latch-free.
    always_comb begin
        base     = 32'(idx) * CHUNK;
        a_slice  = a_r[base +: CHUNK];
        b_slice  = b_r[base +: CHUNK];
        {c_out, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
        // Carry into the slice MSB recovered from the MSB sum bit.
        c_msb    = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ s_slice[CHUNK-1];
        res_next = res;
        res_next[base +: CHUNK] = s_slice;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and carry registers are reset too, not only the
            // control state, so a discarded run leaves nothing behind.
            state <= IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
            Zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= sub ? ~B : B;
                        carry <= Cin ^ sub;
                        idx   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= c_out;
                    if (idx == LAST) begin
                        Sum   <= res_next;
                        Cout  <= c_out;
                        Ovf   <= c_msb ^ c_out;
                        Zero  <= (res_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq_chunked.sv
// Scoreboard bench for addsub_seq_chunked: directed handshake/flag cases on
// 16/4 plus random regression on 16/4, 12/3 and 8/8 against an integer model.
module tb_addsub_seq_chunked;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start16 = 0, sub16 = 0, cin16 = 0;
    logic [15:0] a16 = 0, b16 = 0, sum16;
    logic        busy16, done16, cout16, ovf16, zero16;

    logic        start12 = 0, sub12 = 0, cin12 = 0;
    logic [11:0] a12 = 0, b12 = 0, sum12;
    logic        busy12, done12, cout12, ovf12, zero12;

    logic        start8 = 0, sub8 = 0, cin8 = 0;
    logic [7:0]  a8 = 0, b8 = 0, sum8;
    logic        busy8, done8, cout8, ovf8, zero8;

    addsub_seq_chunked #(.WIDTH(16), .CHUNK(4)) d16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .A(a16), .B(b16), .Cin(cin16),
        .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16), .Ovf(ovf16), .Zero(zero16));
    addsub_seq_chunked #(.WIDTH(12), .CHUNK(3)) d12 (
        .clk(clk), .rst(rst), .start(start12), .sub(sub12), .A(a12), .B(b12), .Cin(cin12),
        .busy(busy12), .done(done12), .Sum(sum12), .Cout(cout12), .Ovf(ovf12), .Zero(zero12));
    addsub_seq_chunked #(.WIDTH(8), .CHUNK(8)) d8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .Ovf(ovf8), .Zero(zero8));

    exp_t q16[$];
    exp_t q12[$];
    exp_t q8[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Exact integer arithmetic; flags follow from range checks on the true result.
    function automatic exp_t model(input int w, input longint a, input longint b,
                                   input bit cin, input bit sub);
        exp_t   r;
        longint full = 64'sd1 <<< w;
        longint half = 64'sd1 <<< (w - 1);
        longint sa   = (a >= half) ? a - full : a;
        longint sb   = (b >= half) ? b - full : b;
        longint eu, es;
        if (!sub) begin
            eu = a + b + longint'(cin);
            es = sa + sb + longint'(cin);
            r.cout = (eu >= full);
        end else begin
            eu = a - b - longint'(cin);
            es = sa - sb - longint'(cin);
            r.cout = (eu >= 0);
        end
        r.ovf  = (es < -half) || (es > half - 1);
        r.sum  = 16'(eu & (full - 1));
        r.zero = (r.sum == 16'h0);
        return r;
    endfunction

    always @(negedge clk) begin : mon16
        exp_t e;
        if (done16) begin
            if (q16.size() == 0) check("d16_unexpected_done", 1, 0);
            else begin
                e = q16.pop_front();
                check("d16_sum", sum16, e.sum);
                check("d16_cout", cout16, e.cout);
                check("d16_ovf", ovf16, e.ovf);
                check("d16_zero", zero16, e.zero);
            end
        end
    end

    always @(negedge clk) begin : mon12
        exp_t e;
        if (done12) begin
            if (q12.size() == 0) check("d12_unexpected_done", 1, 0);
            else begin
                e = q12.pop_front();
                check("d12_sum", sum12, e.sum[11:0]);
                check("d12_cout", cout12, e.cout);
                check("d12_ovf", ovf12, e.ovf);
                check("d12_zero", zero12, e.zero);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) check("d8_unexpected_done", 1, 0);
            else begin
                e = q8.pop_front();
                check("d8_sum", sum8, e.sum[7:0]);
                check("d8_cout", cout8, e.cout);
                check("d8_ovf", ovf8, e.ovf);
                check("d8_zero", zero8, e.zero);
            end
        end
    end

    // One 16-bit operation; optionally pokes start with other operands mid-run.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit cin,
                         input bit sub, input bit poke, output int lat, output int nbusy);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1;
        q16.push_back(model(16, longint'(a), longint'(b), cin, sub));
        lat = 0; nbusy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start16 = 0;
            if (poke && k == 2) begin
                a16 = 16'hAAAA; b16 = 16'h5555; cin16 = ~cin; sub16 = ~sub; start16 = 1;
            end
            if (poke && k == 3) start16 = 0;
            if (busy16) nbusy++;
            if (done16) begin lat = k; break; end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy16, 0);
        check({tag, "_done"}, done16, 0);
        check({tag, "_sum"},  sum16, 0);
        check({tag, "_cout"}, cout16, 0);
        check({tag, "_ovf"},  ovf16, 0);
        check({tag, "_zero"}, zero16, 0);
    endtask

    initial begin
        int lat, nbusy, ndone, t1, t2;
        logic [15:0] ra, rb;
        bit rc, rs;

        repeat (2) @(negedge clk);
        rst = 0;
        check_outputs_zero("reset");

        run16(16'h1234, 16'h0FFF, 0, 0, 0, lat, nbusy);
        check("add_latency", lat, 5);
        check("add_busy_cycles", nbusy, 4);
        run16(16'h7FFF, 16'h0001, 0, 0, 0, lat, nbusy);
        run16(16'hFFFF, 16'h0000, 1, 0, 0, lat, nbusy);
        run16(16'h0005, 16'h0007, 0, 1, 0, lat, nbusy);
        run16(16'h8000, 16'h0001, 0, 1, 0, lat, nbusy);
        check("sub_latency", lat, 5);

        // Start pulsed while busy must not disturb the running operation.
        run16(16'h4321, 16'h1111, 1, 0, 1, lat, nbusy);
        check("poke_latency", lat, 5);
        check("poke_busy_cycles", nbusy, 4);
        repeat (8) @(negedge clk);
        check("poke_no_second_run", busy16, 0);

        // Start held through DONE launches a back-to-back operation.
        @(negedge clk);
        a16 = 16'h00FF; b16 = 16'h0F0F; cin16 = 0; sub16 = 0; start16 = 1;
        q16.push_back(model(16, 64'h00FF, 64'h0F0F, 0, 0));
        t1 = 0; t2 = 0;
        for (int k = 1; k <= 30 && t2 == 0; k++) begin
            @(negedge clk);
            if (k == 1) start16 = 0;
            if (k == 4) begin
                a16 = 16'h1000; b16 = 16'h2001; cin16 = 1; sub16 = 1; start16 = 1;
                q16.push_back(model(16, 64'h1000, 64'h2001, 1, 1));
            end
            if (k == 6) start16 = 0;
            if (done16) begin
                if (t1 == 0) t1 = k;
                else t2 = k;
            end
        end
        check("b2b_first_done", t1, 5);
        check("b2b_second_done", t2, 10);

        // Reset during the second RUN cycle discards the run.
        @(negedge clk);
        a16 = 16'hBEEF; b16 = 16'h0101; cin16 = 0; sub16 = 0; start16 = 1;
        @(negedge clk); start16 = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        check_outputs_zero("midrun_rst");
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done16 || busy16) ndone++;
        end
        check("midrun_rst_quiet", ndone, 0);
        run16(16'h0102, 16'h0304, 0, 0, 0, lat, nbusy);
        check("after_rst_latency", lat, 5);

        // Random regression on all three configurations in parallel.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            @(negedge clk);
            a16 = ra;       b16 = rb;       cin16 = rc; sub16 = rs; start16 = 1;
            a12 = ra[11:0]; b12 = rb[11:0]; cin12 = rc; sub12 = rs; start12 = 1;
            a8  = ra[7:0];  b8  = rb[7:0];  cin8  = rc; sub8  = rs; start8  = 1;
            q16.push_back(model(16, longint'(ra), longint'(rb), rc, rs));
            q12.push_back(model(12, longint'(ra[11:0]), longint'(rb[11:0]), rc, rs));
            q8.push_back(model(8, longint'(ra[7:0]), longint'(rb[7:0]), rc, rs));
            @(negedge clk);
            start16 = 0; start12 = 0; start8 = 0;
            for (int k = 0; k < 20 && (q16.size() + q12.size() + q8.size()) != 0; k++)
                @(negedge clk);
            if ((q16.size() + q12.size() + q8.size()) != 0) begin
                check("random_timeout", 32'(q16.size() + q12.size() + q8.size()), 0);
                q16.delete(); q12.delete(); q8.delete();
            end
        end

        repeat (2) @(negedge clk);
        check("final_queue_empty", 32'(q16.size() + q12.size() + q8.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
